// File: rtl/demux_1_7_capture.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_7_capture
// Description : Steers a serial input bit into one of N_OUT registered slots,
//               either by direct addressed write or by an N_OUT-bit sweep
//               that ends with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_7_capture #(
  parameter int N_OUT   = 7,
  parameter int SEL_W   = 3,
  parameter int CLR_SWP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  input  logic [SEL_W-1:0] func,
  input  logic             load,
  input  logic             start,
  input  logic             in_vld,
  output logic [N_OUT-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [N_OUT-1:0]   out_q,   out_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               err_q,   err_d;

  // Slot selects that fall outside the implemented slots flag an error
  // instead of writing, mirroring a mux that returns 0 for such selects.
  logic               func_ok;
  assign func_ok = (32'(func) < N_OUT);

  // Next-state, slot update and status pulse generation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // start wins over load; the direct write is simply dropped
          state_d = ST_SWEEP;
          idx_d   = '0;
          busy_d  = 1'b1;
          if (CLR_SWP != 0) begin
            out_d = '0;
          end
        end else if (load) begin
          if (func_ok) begin
            for (int k = 0; k < N_OUT; k++) begin
              if (func == SEL_W'(k)) begin
                out_d[k] = in;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SWEEP: begin
        // load/start are not looked at here; nothing is queued
        if (in_vld) begin
          for (int k = 0; k < N_OUT; k++) begin
            if (idx_q == IDX_W'(k)) begin
              out_d[k] = in;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
`default_nettype wire
